// File: rtl/vco_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : vco_sweep_controller
// Description : Steps a VCO through a programmable table of {range, frequency}
//               entries, holding each entry for a fixed number of clocks.
//               Supports single-pass and continuous (wrapping) sweeps, a
//               synchronous stop, and table writes at any time.
// Revision    : 1.0 - initial release
// ============================================================================
module vco_sweep_controller #(
    parameter int DWELL_W = 16,
    parameter int STEP_AW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [STEP_AW-1:0] last_step,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               tbl_wr_en,
    input  logic [STEP_AW-1:0] tbl_wr_addr,
    input  logic [3:0]         tbl_wr_data,
    output logic               range,
    output logic [2:0]         control_frequency,
    output logic               vco_enable,
    output logic               busy,
    output logic [STEP_AW-1:0] step_idx,
    output logic               done
);

    localparam int c_TBL_DEPTH = 2 ** STEP_AW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [3:0]         r_table [c_TBL_DEPTH];
    logic [STEP_AW-1:0] r_step_idx;
    logic [STEP_AW-1:0] r_last_step;
    logic               r_continuous;
    logic [DWELL_W-1:0] r_reload;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_range;
    logic [2:0]         r_control_frequency;
    logic               r_vco_enable;
    logic               r_busy;
    logic               r_done;

    logic [DWELL_W-1:0] w_dwell_reload;
    logic [STEP_AW-1:0] w_next_idx;
    logic               w_at_last;

    // A dwell of zero is treated as one clock, so the reload value saturates at 0
    assign w_dwell_reload = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_W'(1);
    assign w_next_idx     = r_step_idx + STEP_AW'(1);
    assign w_at_last      = (r_step_idx == r_last_step);

    // Step table: writable in any state; loads in the same cycle see the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_TBL_DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (tbl_wr_en) begin
            r_table[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // Sweep sequencer with registered outputs; stop takes priority over stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state             <= S_IDLE;
            r_step_idx          <= '0;
            r_last_step         <= '0;
            r_continuous        <= 1'b0;
            r_reload            <= '0;
            r_dwell_cnt         <= '0;
            r_range             <= 1'b0;
            r_control_frequency <= '0;
            r_vco_enable        <= 1'b0;
            r_busy              <= 1'b0;
            r_done              <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_state                          <= S_RUN;
                        r_step_idx                       <= '0;
                        {r_range, r_control_frequency}   <= r_table[0];
                        r_vco_enable                     <= 1'b1;
                        r_busy                           <= 1'b1;
                        r_last_step                      <= last_step;
                        r_continuous                     <= continuous;
                        r_reload                         <= w_dwell_reload;
                        r_dwell_cnt                      <= w_dwell_reload;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state      <= S_IDLE;
                        r_vco_enable <= 1'b0;
                        r_busy       <= 1'b0;
                    end else if (r_dwell_cnt != '0) begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                    end else if (!w_at_last) begin
                        r_step_idx                     <= w_next_idx;
                        {r_range, r_control_frequency} <= r_table[w_next_idx];
                        r_dwell_cnt                    <= r_reload;
                    end else if (r_continuous) begin
                        r_step_idx                     <= '0;
                        {r_range, r_control_frequency} <= r_table[0];
                        r_dwell_cnt                    <= r_reload;
                    end else begin
                        r_state      <= S_IDLE;
                        r_vco_enable <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign range             = r_range;
    assign control_frequency = r_control_frequency;
    assign vco_enable        = r_vco_enable;
    assign busy              = r_busy;
    assign step_idx          = r_step_idx;
    assign done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vco_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vco_sweep_controller
// Description : Self-checking bench for vco_sweep_controller. Sweep scenarios
//               are table-driven; expected outputs come from a closed-form
//               timing model and pass through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vco_sweep_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       continuous;
    logic [2:0] last_step;
    logic [15:0] dwell_cycles;
    logic       tbl_wr_en;
    logic [2:0] tbl_wr_addr;
    logic [3:0] tbl_wr_data;
    logic       range;
    logic [2:0] control_frequency;
    logic       vco_enable;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    vco_sweep_controller #(.DWELL_W(16), .STEP_AW(3)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .stop              (stop),
        .continuous        (continuous),
        .last_step         (last_step),
        .dwell_cycles      (dwell_cycles),
        .tbl_wr_en         (tbl_wr_en),
        .tbl_wr_addr       (tbl_wr_addr),
        .tbl_wr_data       (tbl_wr_data),
        .range             (range),
        .control_frequency (control_frequency),
        .vco_enable        (vco_enable),
        .busy              (busy),
        .step_idx          (step_idx),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       vco;
        logic       done;
        logic [2:0] idx;
        logic       rng;
        logic [2:0] cf;
    } out_t;

    typedef struct {
        string      name;
        int         L;
        int         D;
        bit         cont;
        int         ncyc;
        bit         poke;
        int         wr_k;
        int         wr_addr;
        logic [3:0] wr_data;
        int         exp_done_k;
    } vec_t;

    out_t       exp_q[$];
    logic [3:0] tb_tbl [8];
    vec_t       vecs [8];
    int         checks   = 0;
    int         failures = 0;

    function automatic vec_t mk(input string name, input int L, input int D, input bit cont,
                                input int ncyc, input bit poke, input int wr_k, input int wr_addr,
                                input logic [3:0] wr_data, input int exp_done_k);
        vec_t v;
        v.name = name; v.L = L; v.D = D; v.cont = cont; v.ncyc = ncyc; v.poke = poke;
        v.wr_k = wr_k; v.wr_addr = wr_addr; v.wr_data = wr_data; v.exp_done_k = exp_done_k;
        return v;
    endfunction

    // Expected outputs k cycles after the start edge (k=0: first cycle of step 0)
    function automatic out_t model(input vec_t v, input int k);
        int         deff;
        int         s;
        int         step;
        int         load_edge;
        logic [3:0] data;
        out_t       r;
        deff = (v.D == 0) ? 1 : v.D;
        s    = k / deff;
        r    = '0;
        if (v.cont) begin
            step = s % (v.L + 1); r.busy = 1'b1; r.vco = 1'b1; load_edge = s * deff;
        end else if (s <= v.L) begin
            step = s; r.busy = 1'b1; r.vco = 1'b1; load_edge = s * deff;
        end else begin
            step = v.L; r.done = (k == (v.L + 1) * deff); load_edge = v.L * deff;
        end
        data = tb_tbl[step];
        // A write lands on edge wr_k+1; only loads on later edges see it
        if (v.wr_k >= 0 && v.wr_addr == step && load_edge > v.wr_k + 1) data = v.wr_data;
        r.idx = 3'(step);
        r.rng = data[3];
        r.cf  = data[2:0];
        return r;
    endfunction

    task automatic check_out(input string name, input int k);
        out_t e;
        out_t a;
        checks++;
        a = {busy, vco_enable, done, step_idx, range, control_frequency};
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s k=%0d: scoreboard empty, got %b", name, k, a);
            return;
        end
        e = exp_q.pop_front();
        if (a !== e) begin
            failures++;
            $display("FAIL %s k=%0d: got busy=%b vco=%b done=%b idx=%0d rng=%b cf=%0d, expected busy=%b vco=%b done=%b idx=%0d rng=%b cf=%0d",
                     name, k, a.busy, a.vco, a.done, a.idx, a.rng, a.cf,
                     e.busy, e.vco, e.done, e.idx, e.rng, e.cf);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic tbl_write(input int addr, input logic [3:0] data);
        @(negedge clk);
        tbl_wr_en = 1'b1; tbl_wr_addr = 3'(addr); tbl_wr_data = data;
        @(negedge clk);
        tbl_wr_en = 1'b0;
        tb_tbl[addr] = data;
    endtask

    task automatic run_vec(input vec_t v);
        out_t last;
        int   done_seen;
        done_seen = -1;
        last      = '0;
        @(negedge clk);
        start = 1'b1; stop = 1'b0;
        last_step = 3'(v.L); dwell_cycles = 16'(v.D); continuous = v.cont;
        for (int k = 0; k < v.ncyc; k++) begin
            last = model(v, k);
            exp_q.push_back(last);
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1 && done_seen < 0) done_seen = k;
            check_out(v.name, k);
            start       = v.poke && (k == 1);
            tbl_wr_en   = (k == v.wr_k);
            tbl_wr_addr = 3'(v.wr_addr);
            tbl_wr_data = v.wr_data;
            if (k == 0) begin
                // Sweep parameters must already be latched; disturb them
                last_step    = ~3'(v.L);
                dwell_cycles = 16'(1 + v.D * 3);
                continuous   = ~v.cont;
            end
        end
        start = 1'b0; tbl_wr_en = 1'b0;
        if (v.cont) begin
            stop = 1'b1;
            last.busy = 1'b0; last.vco = 1'b0; last.done = 1'b0;
            exp_q.push_back(last);
            @(posedge clk);
            @(negedge clk);
            check_out({v.name, "_stop"}, v.ncyc);
            stop = 1'b0;
        end
        check_int({v.name, "_done_cycle"}, done_seen, v.exp_done_k);
        if (v.wr_k >= 0) tb_tbl[v.wr_addr] = v.wr_data;
    endtask

    initial begin
        vecs[0] = mk("pass_l2_d4", 2, 4, 1'b0, 14, 1'b1, -1, 0, 4'h0, 12);
        vecs[1] = mk("cont_l2_d4", 2, 4, 1'b1, 30, 1'b1, -1, 0, 4'h0, -1);
        vecs[2] = mk("dwell0_l1",  1, 0, 1'b0,  4, 1'b1, -1, 0, 4'h0,  2);
        vecs[3] = mk("wr_early",   2, 4, 1'b0, 14, 1'b0,  1, 1, 4'b1110, 12);
        vecs[4] = mk("wr_at_load", 2, 4, 1'b0, 14, 1'b0,  3, 1, 4'b0011, 12);
        vecs[5] = mk("cont_l3_d2", 3, 2, 1'b1, 20, 1'b1, -1, 0, 4'h0, -1);
        vecs[6] = mk("l0_d1",      0, 1, 1'b0,  3, 1'b0, -1, 0, 4'h0,  1);
        vecs[7] = mk("l7_d3",      7, 3, 1'b0, 26, 1'b1, -1, 0, 4'h0, 24);

        for (int i = 0; i < 8; i++) tb_tbl[i] = 4'h0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        last_step = '0; dwell_cycles = '0;
        tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_q.push_back('0);
        check_out("reset_state", 0);
        rst_n = 1'b1;

        // start and stop together in IDLE must not launch a sweep
        start = 1'b1; stop = 1'b1; last_step = 3'd2; dwell_cycles = 16'd4;
        exp_q.push_back('0);
        @(posedge clk);
        @(negedge clk);
        check_out("start_stop_idle", 0);
        start = 1'b0; stop = 1'b0;

        tbl_write(0, 4'b0000);
        tbl_write(1, 4'b0100);
        tbl_write(2, 4'b1001);
        tbl_write(3, 4'b1111);
        tbl_write(4, 4'b0010);
        tbl_write(5, 4'b1101);
        tbl_write(6, 4'b0110);
        tbl_write(7, 4'b1011);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of step 1
        @(negedge clk);
        start = 1'b1; last_step = 3'd2; dwell_cycles = 16'd4; continuous = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_int("pre_reset_step", int'(step_idx), 1);
        rst_n = 1'b0;
        exp_q.push_back('0);
        #1;
        check_out("async_reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tb_tbl[i] = 4'h0;
        exp_q.push_back('0);
        @(posedge clk);
        @(negedge clk);
        check_out("idle_after_release", 0);

        // Table must read back as all zeros after reset
        run_vec(mk("zero_table", 7, 1, 1'b0, 10, 1'b0, -1, 0, 4'h0, 8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
